// File: rtl/ra_return_stack.sv
// Return-address stack: calls push the link address, returns pop a predicted
// target, and a commit-side check port scores each prediction.
module ra_return_stack #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push_valid,
  input  logic [N-1:0]       push_addr,
  input  logic               pop_valid,
  output logic [N-1:0]       pred_addr,
  output logic               pred_valid,
  output logic               empty,
  output logic               full,
  output logic [PTR_W:0]     count,
  input  logic               chk_valid,
  input  logic [N-1:0]       chk_pred,
  input  logic [N-1:0]       chk_actual,
  output logic               mispredict,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  logic [N-1:0]       stack_q [DEPTH];
  logic [PTR_W-1:0]   top_q, top_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_idx;
  logic               mispredict_q, mispredict_d;
  logic [CNT_W-1:0]   hit_q, hit_d, miss_q, miss_d;
  logic               is_empty, is_full, chk_match;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == (PTR_W + 1)'(DEPTH));

  // Stack pointer / occupancy next state; flush dominates, then push+pop.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    if (flush) begin
      top_d   = '0;
      count_d = '0;
    end else if (push_valid && (!pop_valid || is_empty)) begin
      top_d   = top_q + PTR_W'(1);
      wr_en   = 1'b1;
      wr_idx  = top_q + PTR_W'(1);
      count_d = is_full ? count_q : count_q + (PTR_W + 1)'(1);
    end else if (push_valid && pop_valid) begin
      // Coroutine jump: replace the top entry in place.
      wr_en  = 1'b1;
      wr_idx = top_q;
    end else if (pop_valid && !is_empty) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else if (wr_en) begin
      stack_q[wr_idx] <= push_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Check port runs regardless of flush/push/pop.
  assign chk_match = (chk_pred == chk_actual);

  always_comb begin
    mispredict_d = chk_valid && !chk_match;
    hit_d        = hit_q;
    miss_d       = miss_q;
    if (chk_valid && chk_match && (hit_q != '1)) begin
      hit_d = hit_q + CNT_W'(1);
    end
    if (chk_valid && !chk_match && (miss_q != '1)) begin
      miss_d = miss_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign pred_addr  = is_empty ? '0 : stack_q[top_q];
  assign pred_valid = !is_empty;
  assign empty      = is_empty;
  assign full       = is_full;
  assign count      = count_q;
  assign mispredict = mispredict_q;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_ra_return_stack.sv
// Directed bench for ra_return_stack with a queue-based reference stack and a
// queue of expected mispredict results.
module tb_ra_return_stack;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_addr = '0;
  logic        pop_valid = 1'b0;
  logic [31:0] pred_addr;
  logic        pred_valid;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        chk_valid = 1'b0;
  logic [31:0] chk_pred = '0;
  logic [31:0] chk_actual = '0;
  logic        mispredict;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] model[$];
  logic        exp_mis[$];
  logic [31:0] exp_hit = '0;
  logic [31:0] exp_miss = '0;

  always #5 clk = ~clk;

  ra_return_stack #(
    .N(32), .DEPTH(8), .PTR_W(3), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (push_valid),
    .push_addr  (push_addr),
    .pop_valid  (pop_valid),
    .pred_addr  (pred_addr),
    .pred_valid (pred_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .chk_valid  (chk_valid),
    .chk_pred   (chk_pred),
    .chk_actual (chk_actual),
    .mispredict (mispredict),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_pred;
    exp_pred = (model.size() != 0) ? model[model.size()-1] : 32'h0;
    check({tag, ".count"}, {28'h0, count}, 32'(model.size()));
    check({tag, ".pred_addr"}, pred_addr, exp_pred);
    check({tag, ".pred_valid"}, {31'h0, pred_valid}, {31'h0, model.size() != 0});
    check({tag, ".empty"}, {31'h0, empty}, {31'h0, model.size() == 0});
    check({tag, ".full"}, {31'h0, full}, {31'h0, model.size() == 8});
  endtask

  // One clock with the given stack controls; outputs sampled 1ns after the edge.
  task automatic cycle(input logic fl, input logic pu, input logic [31:0] addr, input logic po);
    flush      = fl;
    push_valid = pu;
    push_addr  = addr;
    pop_valid  = po;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    push_valid = 1'b0;
    pop_valid  = 1'b0;
    if (fl) begin
      model.delete();
    end else if (pu && po && model.size() != 0) begin
      model[model.size()-1] = addr;
    end else if (pu) begin
      model.push_back(addr);
      if (model.size() > 8) void'(model.pop_front());
    end else if (po && model.size() != 0) begin
      void'(model.pop_back());
    end
  endtask

  task automatic chk(input logic [31:0] p, input logic [31:0] a);
    chk_valid  = 1'b1;
    chk_pred   = p;
    chk_actual = a;
    exp_mis.push_back(p != a);
    if (p == a) exp_hit++;
    else        exp_miss++;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    check("mispredict", {31'h0, mispredict}, {31'h0, exp_mis.pop_front()});
  endtask

  initial begin
    #3;
    check("rst.count", {28'h0, count}, 32'h0);
    check("rst.pred_addr", pred_addr, 32'h0);
    check("rst.pred_valid", {31'h0, pred_valid}, 32'h0);
    check("rst.empty", {31'h0, empty}, 32'h1);
    check("rst.full", {31'h0, full}, 32'h0);
    check("rst.mispredict", {31'h0, mispredict}, 32'h0);
    check("rst.hit_cnt", {16'h0, hit_cnt}, 32'h0);
    check("rst.miss_cnt", {16'h0, miss_cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Basic push / pop.
    cycle(1'b0, 1'b1, 32'h104, 1'b0);
    cycle(1'b0, 1'b1, 32'h208, 1'b0);
    cycle(1'b0, 1'b1, 32'h30C, 1'b0);
    check("t1.count", {28'h0, count}, 32'h3);
    check("t1.pred", pred_addr, 32'h30C);
    check_state("t1.push");
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1.pop1", pred_addr, 32'h208);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1.pop2", pred_addr, 32'h104);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1.pop3_valid", {31'h0, pred_valid}, 32'h0);
    check("t1.pop3_empty", {31'h0, empty}, 32'h1);

    // Overflow wrap-around.
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 32'h100 + 32'(4 * k), 1'b0);
    check("t2.full", {31'h0, full}, 32'h1);
    check("t2.count", {28'h0, count}, 32'h8);
    for (int i = 0; i < 8; i++) begin
      check("t2.pop_pred", pred_addr, 32'h124 - 32'(4 * i));
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check_state("t2.pop");
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2.pop9_count", {28'h0, count}, 32'h0);

    // Underflow.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      check("t3.count", {28'h0, count}, 32'h0);
      check("t3.pred", pred_addr, 32'h0);
    end
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    check("t3.push_pred", pred_addr, 32'h40);
    check("t3.push_count", {28'h0, count}, 32'h1);

    // Simultaneous push and pop.
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h10, 1'b0);
    cycle(1'b0, 1'b1, 32'h20, 1'b0);
    cycle(1'b0, 1'b1, 32'h99, 1'b1);
    check("t4.count", {28'h0, count}, 32'h2);
    check("t4.pred", pred_addr, 32'h99);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4.pop", pred_addr, 32'h10);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h77, 1'b1);
    check_state("t4.pushpop_empty");

    // Flush beats push.
    cycle(1'b0, 1'b1, 32'h1, 1'b0);
    cycle(1'b0, 1'b1, 32'h2, 1'b0);
    cycle(1'b0, 1'b1, 32'h3, 1'b0);
    cycle(1'b1, 1'b1, 32'h55, 1'b0);
    check("t5.count", {28'h0, count}, 32'h0);
    check("t5.empty", {31'h0, empty}, 32'h1);
    cycle(1'b0, 1'b1, 32'h60, 1'b0);
    check("t5.pred", pred_addr, 32'h60);
    check("t5.count2", {28'h0, count}, 32'h1);

    // Check port.
    chk(32'h200, 32'h200);
    chk(32'h200, 32'h204);
    chk(32'h300, 32'h300);
    check("t6.hit", {16'h0, hit_cnt}, exp_hit);
    check("t6.miss", {16'h0, miss_cnt}, exp_miss);
    check("t6.hit_const", {16'h0, hit_cnt}, 32'h2);
    check("t6.miss_const", {16'h0, miss_cnt}, 32'h1);
    @(posedge clk);
    #1;
    check("t6.idle_mis", {31'h0, mispredict}, 32'h0);

    // Asynchronous reset mid-operation.
    cycle(1'b0, 1'b1, 32'hA0, 1'b0);
    chk_valid  = 1'b1;
    chk_pred   = 32'h1;
    chk_actual = 32'h2;
    push_valid = 1'b1;
    push_addr  = 32'hB0;
    #2;
    reset = 1'b0;
    #1;
    check("t7.hit", {16'h0, hit_cnt}, 32'h0);
    check("t7.miss", {16'h0, miss_cnt}, 32'h0);
    check("t7.count", {28'h0, count}, 32'h0);
    check("t7.mispredict", {31'h0, mispredict}, 32'h0);
    model.delete();
    chk_valid  = 1'b0;
    push_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 1'b1, 32'hC0, 1'b0);
    check_state("t7.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
